// File: rtl/pdp8_pkg.sv
// Shared PDP-8 I/O definitions: IOT microcode bits, device codes, teleprinter FSM states.
package pdp8_pkg;

    localparam int unsigned IOT_SKIP = 0;
    localparam int unsigned IOT_CLRF = 1;
    localparam int unsigned IOT_LOAD = 2;

    localparam logic [5:0] DEV_TTO = 6'o04;

    localparam int unsigned TIMER_W = 16;
    localparam int unsigned CHAR_W  = 8;
    localparam int unsigned BITCNT_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tto_state_t;

endpackage

// File: rtl/tto_bit_timer.sv
// Serial bit-period timer: counts DIVISOR-1 down to 0, ticks at 0 and reloads.
module tto_bit_timer
    import pdp8_pkg::*;
#(
    parameter int unsigned DIVISOR = 174
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic restart,
    output logic tick
);

    localparam logic [TIMER_W-1:0] RELOAD = TIMER_W'(DIVISOR - 1);

    logic [TIMER_W-1:0] cnt;

    // tick is kept registered and always equals (cnt == 0)
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else if (restart || tick) begin
            cnt  <= RELOAD;
            tick <= 1'b0;
        end else begin
            cnt  <= cnt - TIMER_W'(1);
            tick <= (cnt == TIMER_W'(1));
        end
    end

endmodule

// File: rtl/kl8_tto.sv
// KL8 teleprinter output (device 04): AC character serialiser with one-deep hold
// register, printer flag, skip and interrupt.
module kl8_tto
    import pdp8_pkg::*;
#(
    parameter int unsigned DIVISOR   = 174,
    parameter int unsigned STOP_BITS = 2
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        IOT,
    input  logic        SEL,
    input  logic [2:0]  OP,
    input  logic [11:0] AC,
    output logic        SKIP,
    output logic        IRQ,
    output logic        FLAG,
    output logic        BUSY,
    output logic        TXD
);

    tto_state_t          state, state_n;
    logic [CHAR_W-1:0]   shreg, shreg_n;
    logic [CHAR_W-1:0]   hold, hold_n;
    logic                hold_full, hold_full_n;
    logic [BITCNT_W-1:0] bitcnt, bitcnt_n;
    logic                flag_n, busy_n, txd_n;
    logic                restart, tick, frame_done;
    logic                dev, load, clr;
    logic                unused_ac;

    assign unused_ac = ^AC[11:8];

    assign dev  = IOT & SEL;
    assign load = dev & OP[IOT_LOAD];
    assign clr  = dev & OP[IOT_CLRF];

    assign SKIP = dev & OP[IOT_SKIP] & FLAG;
    assign IRQ  = FLAG;

    tto_bit_timer #(
        .DIVISOR (DIVISOR)
    ) u_timer (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .restart (restart),
        .tick    (tick)
    );

    // Next-state, shifter, hold and flag logic
    always_comb begin
        state_n     = state;
        shreg_n     = shreg;
        hold_n      = hold;
        hold_full_n = hold_full;
        bitcnt_n    = bitcnt;
        flag_n      = FLAG;
        restart     = 1'b0;
        frame_done  = 1'b0;

        if (clr) begin
            flag_n = 1'b0;
        end
        // Any load while a frame is in flight lands in (or overwrites) the hold register
        if (load && state != IDLE) begin
            hold_n      = AC[CHAR_W-1:0];
            hold_full_n = 1'b1;
        end

        case (state)
            IDLE: begin
                if (load) begin
                    state_n = START;
                    shreg_n = AC[CHAR_W-1:0];
                    restart = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_n  = DATA;
                    bitcnt_n = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    shreg_n = {1'b0, shreg[CHAR_W-1:1]};
                    if (bitcnt == BITCNT_W'(CHAR_W - 1)) begin
                        state_n  = STOP;
                        bitcnt_n = '0;
                    end else begin
                        bitcnt_n = bitcnt + BITCNT_W'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (bitcnt == BITCNT_W'(STOP_BITS - 1)) begin
                        frame_done = 1'b1;
                        if (hold_full) begin
                            state_n     = START;
                            shreg_n     = hold;
                            hold_full_n = load;
                        end else if (load) begin
                            state_n     = START;
                            shreg_n     = AC[CHAR_W-1:0];
                            hold_full_n = 1'b0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        bitcnt_n = bitcnt + BITCNT_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Completion set wins over a same-cycle clear
        if (frame_done) begin
            flag_n = 1'b1;
        end

        case (state_n)
            START:   txd_n = 1'b0;
            DATA:    txd_n = shreg_n[0];
            default: txd_n = 1'b1;
        endcase

        busy_n = (state_n != IDLE) | hold_full_n;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            shreg     <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            bitcnt    <= '0;
            FLAG      <= 1'b0;
            BUSY      <= 1'b0;
            TXD       <= 1'b1;
        end else begin
            state     <= state_n;
            shreg     <= shreg_n;
            hold      <= hold_n;
            hold_full <= hold_full_n;
            bitcnt    <= bitcnt_n;
            FLAG      <= flag_n;
            BUSY      <= busy_n;
            TXD       <= txd_n;
        end
    end

endmodule

// File: tb/tb_kl8_tto.sv
// Bench for kl8_tto: frame-level reference model, serial receiver monitor and scoreboard.
module tb_kl8_tto;

    localparam int unsigned D  = 4;
    localparam int unsigned SB = 2;
    localparam int unsigned FL = (9 + SB) * D;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        iot   = 1'b0;
    logic        sel   = 1'b0;
    logic [2:0]  op    = 3'd0;
    logic [11:0] ac    = 12'd0;
    logic        skip, irq, flag, busy, txd;

    kl8_tto #(.DIVISOR(D), .STOP_BITS(SB)) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .IOT     (iot),
        .SEL     (sel),
        .OP      (op),
        .AC      (ac),
        .SKIP    (skip),
        .IRQ     (irq),
        .FLAG    (flag),
        .BUSY    (busy),
        .TXD     (txd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] ch;
        int         start;
    } frame_t;

    frame_t exp_q[$];
    int checks   = 0;
    int failures = 0;
    bit end_req  = 1'b0;
    bit end_done = 1'b0;

    // Reference model: the frame currently on the line plus at most one pending character
    bit         m_flag  = 1'b0;
    bit         cur_v   = 1'b0;
    int         cur_start, cur_end;
    logic [7:0] cur_ch;
    bit         pend_v  = 1'b0;
    logic [7:0] pend_ch;

    // Receiver-side monitor state
    bit         rx_act  = 1'b0;
    int         rx_start;
    logic [7:0] rx_ch;
    logic       prev_txd = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic start_frame(input logic [7:0] ch, input int s);
        frame_t f;
        cur_v     = 1'b1;
        cur_ch    = ch;
        cur_start = s;
        cur_end   = s + int'(FL) - 1;
        f.ch      = ch;
        f.start   = s;
        exp_q.push_back(f);
    endtask

    function automatic int model_txd(input int c);
        int k;
        if (cur_v && c >= cur_start && c <= cur_end) begin
            k = (c - cur_start) / int'(D);
            if (k == 0) return 0;
            if (k <= 8) return int'(cur_ch[k-1]);
        end
        return 1;
    endfunction

    always @(negedge clk) begin
        bit L, C, ending, idle, nf;
        int off, k;
        frame_t f;
        if (!rst_n) begin
            chk("rst_txd", txd, 1);
            chk("rst_flag", flag, 0);
            chk("rst_irq", irq, 0);
            chk("rst_busy", busy, 0);
            m_flag   = 1'b0;
            cur_v    = 1'b0;
            pend_v   = 1'b0;
            rx_act   = 1'b0;
            prev_txd = 1'b1;
            exp_q.delete();
        end else begin
            chk("txd", txd, model_txd(cyc));
            chk("flag", flag, m_flag);
            chk("irq", irq, m_flag);
            chk("busy", busy, int'((cur_v && cyc <= cur_end) || pend_v));
            chk("skip", skip, int'(iot && sel && op[0] && m_flag));

            // Monitor: decode frames from TXD and match against the scoreboard
            if (!rx_act) begin
                if (prev_txd && !txd) begin
                    rx_act   = 1'b1;
                    rx_start = cyc;
                end
            end else begin
                off = cyc - rx_start;
                k   = off / int'(D);
                if (off % int'(D) == int'(D / 2)) begin
                    if (k >= 1 && k <= 8) rx_ch[k-1] = txd;
                    if (k >= 9) chk("stop_bit", txd, 1);
                end
                if (off == int'(FL) - 1) begin
                    rx_act = 1'b0;
                    chk("frame_expected", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        f = exp_q.pop_front();
                        chk("frame_char", rx_ch, f.ch);
                        chk("frame_start", rx_start, f.start);
                    end
                end
            end
            prev_txd = txd;

            // Model update with this cycle's IOT
            L      = iot && sel && op[2];
            C      = iot && sel && op[1];
            ending = cur_v && cyc == cur_end;
            idle   = !cur_v || cyc > cur_end;
            nf     = m_flag;
            if (C) nf = 1'b0;
            if (ending) nf = 1'b1;
            if (ending) begin
                if (pend_v) begin
                    start_frame(pend_ch, cyc + 1);
                    pend_v = L;
                    if (L) pend_ch = ac[7:0];
                end else if (L) begin
                    start_frame(ac[7:0], cyc + 1);
                end
            end else if (idle) begin
                if (L) start_frame(ac[7:0], cyc + 1);
            end else if (L) begin
                pend_v  = 1'b1;
                pend_ch = ac[7:0];
            end
            m_flag = nf;

            if (end_req && !end_done) begin
                chk("drain", exp_q.size(), 0);
                chk("rx_idle", int'(rx_act), 0);
                end_done = 1'b1;
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic iot_op(input logic [2:0] o, input logic [11:0] a, input bit s);
        iot = 1'b1;
        sel = s;
        op  = o;
        ac  = a;
        @(posedge clk);
        #1;
        iot = 1'b0;
        sel = 1'b0;
        op  = 3'd0;
        ac  = 12'($urandom);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_cyc(2);

        // Reset in the middle of a frame
        iot_op(3'b110, 12'h055, 1'b1);
        wait_cyc(8);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_cyc(20);

        // Single character, then skip/clear/skip
        iot_op(3'b110, 12'o0301, 1'b1);
        wait_cyc(50);
        iot_op(3'b001, 12'd0, 1'b1);
        iot_op(3'b010, 12'd0, 1'b1);
        iot_op(3'b001, 12'd0, 1'b1);

        // Back-to-back via hold register
        iot_op(3'b110, 12'h041, 1'b1);
        wait_cyc(4);
        iot_op(3'b100, 12'h042, 1'b1);
        wait_cyc(100);

        // Hold overwrite
        iot_op(3'b110, 12'h041, 1'b1);
        wait_cyc(4);
        iot_op(3'b100, 12'h042, 1'b1);
        wait_cyc(4);
        iot_op(3'b100, 12'h043, 1'b1);
        wait_cyc(100);

        // TCF in the final stop cycle
        iot_op(3'b110, 12'h05a, 1'b1);
        wait_cyc(43);
        iot_op(3'b010, 12'd0, 1'b1);
        wait_cyc(3);

        // TLS in the final stop cycle with hold empty
        iot_op(3'b110, 12'h03c, 1'b1);
        wait_cyc(43);
        iot_op(3'b110, 12'hf99, 1'b1);
        wait_cyc(100);

        // Decode qualification
        iot_op(3'b010, 12'd0, 1'b1);
        iot_op(3'b110, 12'h0ff, 1'b0);
        wait_cyc(10);
        iot_op(3'b001, 12'd0, 1'b1);
        wait_cyc(4);

        // Randomised traffic
        repeat (400) begin
            if ($urandom_range(0, 3) == 0)
                iot_op(3'($urandom_range(0, 7)), 12'($urandom), ($urandom_range(0, 4) != 0));
            else
                wait_cyc(int'($urandom_range(1, 12)));
        end

        wait_cyc(200);
        end_req = 1'b1;
        wait_cyc(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
